// File: rtl/axi_reg_arbiter_pkg.sv
// Shared types and constants for the two-port AXI register arbiter.
package axi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

endpackage

// File: rtl/axi_reg_arbiter_if.sv
// AXI channel bundle between the arbiter (master) and the register slave.
interface axi_reg_arbiter_if #(
  parameter int unsigned ID_W   = axi_reg_pkg::AXI_ID_W,
  parameter int unsigned ADDR_W = axi_reg_pkg::AXI_ADDR_W,
  parameter int unsigned DATA_W = axi_reg_pkg::AXI_DATA_W
);
  logic [ID_W-1:0]     awid_o;
  logic [ADDR_W-1:0]   awaddr_o;
  logic                awvalid_o;
  logic                awready_i;
  logic [ID_W-1:0]     wid_o;
  logic [DATA_W-1:0]   wdata_o;
  logic [DATA_W/8-1:0] wstrb_o;
  logic                wlast_o;
  logic                wvalid_o;
  logic                wready_i;
  logic [ID_W-1:0]     bid_i;
  logic [1:0]          bresp_i;
  logic                bvalid_i;
  logic                bready_o;
  logic [ID_W-1:0]     arid_o;
  logic [ADDR_W-1:0]   araddr_o;
  logic                arvalid_o;
  logic                arready_i;
  logic [ID_W-1:0]     rid_i;
  logic [DATA_W-1:0]   rdata_i;
  logic [1:0]          rresp_i;
  logic                rlast_i;
  logic                rvalid_i;
  logic                rready_o;

  modport master (
    output awid_o, awaddr_o, awvalid_o, wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
           bready_o, arid_o, araddr_o, arvalid_o, rready_o,
    input  awready_i, wready_i, bid_i, bresp_i, bvalid_i, arready_i,
           rid_i, rdata_i, rresp_i, rlast_i, rvalid_i
  );

  modport slave (
    input  awid_o, awaddr_o, awvalid_o, wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
           bready_o, arid_o, araddr_o, arvalid_o, rready_o,
    output awready_i, wready_i, bid_i, bresp_i, bvalid_i, arready_i,
           rid_i, rdata_i, rresp_i, rlast_i, rvalid_i
  );
endinterface

// File: rtl/axi_reg_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; priority goes to the requester not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       areset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       last
);

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  // Resetting to 1 makes requester 0 win the first tie.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset)
      last <= 1'b1;
    else if (advance && (|gnt))
      last <= gnt[1];
  end

endmodule

// File: rtl/axi_reg_arbiter.sv
// Shares the AXI register slave between two local requesters, one
// single-beat command at a time, granted round-robin.
module axi_reg_arbiter
  import axi_reg_pkg::*;
#(
  parameter int unsigned ID_W   = AXI_ID_W,
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [1:0]            req_valid_i,
  input  logic [1:0]            req_we_i,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  input  logic [2*DATA_W-1:0]   req_wdata_i,
  input  logic [2*DATA_W/8-1:0] req_wstrb_i,
  output logic [1:0]            req_ready_o,
  output logic [1:0]            resp_valid_o,
  output logic [DATA_W-1:0]     resp_rdata_o,
  output logic                  resp_err_o,
  axi_reg_arbiter_if.master     axi
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_t state, state_nxt;

  logic [1:0]        gnt;
  logic              gsel;
  logic              unused_last_gnt;
  logic              unused_rlast;
  logic              cur_g;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [STRB_W-1:0] cur_wstrb;
  logic              aw_done, w_done;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic              take, aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign unused_rlast = axi.rlast_i;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .areset  (areset),
    .req     (req_valid_i),
    .advance (take),
    .gnt     (gnt),
    .last    (unused_last_gnt)
  );

  assign gsel  = gnt[1];
  assign take  = (state == IDLE) && (|req_valid_i);
  assign aw_hs = awvalid & axi.awready_i;
  assign w_hs  = wvalid  & axi.wready_i;
  assign b_hs  = bready  & axi.bvalid_i;
  assign ar_hs = arvalid & axi.arready_i;
  assign r_hs  = rready  & axi.rvalid_i;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = req_we_i[gsel] ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (b_hs) state_nxt = IDLE;
      RD_REQ:  if (ar_hs) state_nxt = RD_RESP;
      RD_RESP: if (r_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // AW and W valids fall independently once their own handshake is recorded.
  always_comb begin
    req_ready_o = '0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    unique case (state)
      IDLE:    req_ready_o = gnt;
      WR_REQ:  begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      WR_RESP: bready  = 1'b1;
      RD_REQ:  arvalid = 1'b1;
      RD_RESP: rready  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      cur_g     <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_wstrb <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else if (take) begin
      cur_g     <= gsel;
      cur_addr  <= gsel ? req_addr_i[2*ADDR_W-1:ADDR_W]  : req_addr_i[ADDR_W-1:0];
      cur_wdata <= gsel ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
      cur_wstrb <= gsel ? req_wstrb_i[2*STRB_W-1:STRB_W] : req_wstrb_i[STRB_W-1:0];
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      resp_valid_o <= '0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      resp_valid_o <= '0;
      if (b_hs) begin
        resp_valid_o <= {cur_g, ~cur_g};
        resp_rdata_o <= '0;
        resp_err_o   <= (axi.bresp_i != RESP_OKAY) | (axi.bid_i != ID_W'(cur_g));
      end else if (r_hs) begin
        resp_valid_o <= {cur_g, ~cur_g};
        resp_rdata_o <= axi.rdata_i;
        resp_err_o   <= (axi.rresp_i != RESP_OKAY) | (axi.rid_i != ID_W'(cur_g));
      end
    end
  end

  assign axi.awid_o    = ID_W'(cur_g);
  assign axi.awaddr_o  = cur_addr;
  assign axi.awvalid_o = awvalid;
  assign axi.wid_o     = ID_W'(cur_g);
  assign axi.wdata_o   = cur_wdata;
  assign axi.wstrb_o   = cur_wstrb;
  assign axi.wlast_o   = 1'b1;
  assign axi.wvalid_o  = wvalid;
  assign axi.bready_o  = bready;
  assign axi.arid_o    = ID_W'(cur_g);
  assign axi.araddr_o  = cur_addr;
  assign axi.arvalid_o = arvalid;
  assign axi.rready_o  = rready;

endmodule

// File: doc/axi_reg_arbiter.md
# axi_reg_arbiter

Two-port arbiter and AXI master sequencer that shares the 8-word AXI register slave (the counter register file) between two local requesters. Each requester issues single-beat read or write commands over a simple valid/ready port. The block grants one command at a time in round-robin order, drives the full AXI write (AW+W then B) or read (AR then R) transaction, and returns read data and status to the granted requester. It sits between the counter control logic and the register slave.

## Interface
- ID_W, 4, AXI ID width; the requester index is zero-extended into awid/arid.
- ADDR_W, 32, address width; passed through unchanged.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- clk  in  1  single clock, all logic rising-edge.
- areset  in  1  asynchronous, active-low reset.
- req_valid_i  in  2  per-requester command valid; held until req_ready_o.
- req_we_i  in  2  1 = write, 0 = read.
- req_addr_i  in  2×ADDR_W  command address.
- req_wdata_i  in  2×DATA_W  write data.
- req_wstrb_i  in  2×DATA_W/8  write byte strobes.
- req_ready_o  out  2  one-cycle grant/accept pulse.
- resp_valid_o  out  2  one-cycle completion pulse (no backpressure).
- resp_rdata_o  out  DATA_W  read data for the completed read; 0 for writes.
- resp_err_o  out  1  valid with resp_valid_o: non-OKAY response or ID mismatch.
- awid_o/awaddr_o/awvalid_o out, awready_i in: AXI write address channel.
- wid_o/wdata_o/wstrb_o/wlast_o/wvalid_o out, wready_i in: AXI write data channel. wlast_o is tied to 1.
- bid_i/bresp_i/bvalid_i in, bready_o out: AXI write response channel.
- arid_o/araddr_o/arvalid_o out, arready_i in: AXI read address channel.
- rid_i/rdata_i/rresp_i/rlast_i/rvalid_i in, rready_o out: AXI read data channel. rlast_i is ignored.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- **IDLE:**
  - If any req_valid_i is set, grant one requester by round-robin.
  - Pulse req_ready_o[g] and capture we/addr/wdata/wstrb and g.
  - Go to WR_REQ if we=1, else RD_REQ.
- **Round-robin rule:**
  - Priority goes to the requester not granted last.
  - The last-grant register resets to 1, so requester 0 wins the first tie.
- **WR_REQ:**
  - awvalid_o and wvalid_o rise together on entry.
  - Each drops independently, the cycle after its own handshake (valid & ready).
  - Exit to WR_RESP once both handshakes are done; same-cycle handshakes are allowed.
  - Valids never drop before their handshake.
- **WR_RESP:**
  - bready_o=1.
  - On the bvalid_i handshake, go to IDLE and complete with err = (bresp_i≠OKAY) | (bid_i≠g).
- **RD_REQ:** arvalid_o=1 until the arready_i handshake, then go to RD_RESP.
- **RD_RESP:**
  - rready_o=1.
  - On the rvalid_i handshake, go to IDLE and complete with rdata=rdata_i, err = (rresp_i≠OKAY) | (rid_i≠g).
- **Completion:**
  - Registered, so resp_valid_o[g]=1 for exactly one cycle after the B/R handshake.
  - resp_rdata_o/resp_err_o are held until the next completion.
- A requester that drops req_valid_i before the grant is not served. This is not an error.
- A B or R beat arriving outside its wait state is ignored: ready stays low.

## Timing
- **Reset values:**
  - All *valid_o, *ready_o and resp_valid_o are 0.
  - resp_rdata_o=0, resp_err_o=0.
  - AXI address/data/id/strobe outputs are 0; wlast_o=1.
  - State is IDLE.
- **Grant:** cycle T (req_ready_o pulse); awvalid_o/wvalid_o/arvalid_o are high from T+1.
- **Completion:** B/R handshake at cycle H gives resp_valid_o at H+1. IDLE is re-entered at H+1, and the next grant can occur at H+1.
- Minimum write with an always-ready slave: grant T, AW/W at T+1, B at T+2 or later, resp at T+3 or later.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously, the transaction is abandoned, and no response is issued.
- Both requesters valid continuously: grants strictly alternate.

## Structure
- Package axi_reg_pkg holds:
  - state enum arb_state_t;
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - default ID_W/ADDR_W/DATA_W constants.
- One sub-module: rr_arb2, a 2-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: one-hot gnt[1:0] and last-grant state.
- The FSM, capture registers and AXI channel drivers live in the top level.

## Test plan
- Req0 writes addr 3, data 0xDEADBEEF, strb 0xF; slave bresp OKAY, bid 0 → resp_valid_o[0] one cycle, err 0; awid_o=0, awaddr_o=3.
- Req1 reads addr 3 after that write; slave returns 0xDEADBEEF, rid 1 → resp_valid_o[1], resp_rdata_o=0xDEADBEEF, err 0.
- Both requesters valid for 4 commands each → grant order 0,1,0,1,…; no command lost or duplicated.
- Slave holds awready_i low for 3 cycles while wready_i=1 → wvalid_o drops after 1 cycle, awvalid_o stays high until its handshake, exactly one B is awaited.
- Slave returns bresp SLVERR on a write, and rid 0 for a req1 read → resp_err_o=1 in both cases.
- areset asserted during RD_RESP → all valids/readys drop immediately, no resp_valid_o, and the first grant after release goes to requester 0.
